serial_add_seq: RTL and testbench
=================================

// Module: serial_add_seq
// PURPOSE
//  Bit-serial N-bit adder. Operands are loaded in parallel, then fed LSB-first one bit per
//  clock through a single full-adder cell; a carry flop closes the loop between bits.
//  Sits directly upstream of the full-adder cell: it sequences operand bits into the cell
//  and collects sum/carry back. Trades area for latency versus a ripple chain of fulladders.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits, >= 1
// PORTS
//  clk     in   1      single clock, rising edge
//  rst     in   1      synchronous reset, active-high
//  start   in   1      request: latch a/b/ci and begin; honoured only in IDLE
//  a       in   WIDTH  operand A, sampled on accepted start
//  b       in   WIDTH  operand B, sampled on accepted start
//  ci      in   1      carry-in, sampled on accepted start
//  busy    out  1      high in RUN and DONE
//  done    out  1      one-cycle pulse: sum/co valid
//  sum     out  WIDTH  result register
//  co      out  1      final carry-out
//  ovf     out  1      signed overflow (only with SERIAL_ADD_OVF_EN)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, sum=0, co=0, ovf=0; operand shifters, carry flop
//   and bit counter cleared. Reset wins over every other input in the same cycle.
//  States: IDLE -> RUN on start; RUN -> DONE after WIDTH bit cycles; DONE -> IDLE unconditionally.
//  IDLE: start=1 loads shift regs A<=a, B<=b, carry<=ci, cnt<=0, sum<=0; else hold outputs.
//  RUN, each cycle: s=A[0]^B[0]^carry; c=(A[0]&B[0])|(carry&(A[0]^B[0]));
//   sum <= {s, sum[WIDTH-1:1]} (shift in from MSB); A,B >>1; carry<=c; cnt<=cnt+1.
//   On cnt==WIDTH-1 the bit is processed, co<=c, go DONE.
//  DONE: done=1 for exactly one cycle; busy=1; sum/co final.
//  Latency: start sampled at edge 0 -> done high during cycle WIDTH+1 (9 for WIDTH=8).
//  sum/co hold final values in IDLE until the next accepted start (sum cleared at load).
//  start while busy (RUN or DONE): ignored, no queueing; operands on a/b not re-sampled.
//  start in the cycle IDLE is re-entered: accepted (back-to-back ops, WIDTH+2 cycle period).
//  Counter width: $clog2(WIDTH) bits, min 1; no wrap beyond WIDTH-1.
//  Result equals {co,sum} == a + b + ci modulo 2^(WIDTH+1), all unsigned.
//  rst mid-RUN: abort, outputs to reset values, no done pulse.
//  WIDTH=1: RUN lasts one cycle; done at cycle 2.
// CONFIGURATION
//  `define SERIAL_ADD_OVF_EN: adds port ovf. On the last RUN bit, ovf <= carry_in_to_msb ^ c
//   (two's-complement overflow); cleared at load and by reset; holds with sum.
//  Without it: no ovf port, no extra flop; all other behaviour identical.
// TESTING
//  1. WIDTH=8, a=8'hFF b=8'h01 ci=0 start 1 cycle -> done at cycle 9, sum=8'h00 co=1.
//  2. a=8'h3C b=8'h05 ci=1 -> sum=8'h42 co=0; busy high cycles 1..9, low at 10.
//  3. Start op a=8'h10 b=8'h20, pulse start again at cycle 4 with a=8'hFF -> ignored, sum=8'h30.
//  4. Start a=8'hAA b=8'h55, assert rst at cycle 5 -> no done pulse, sum=0 co=0 busy=0 next cycle.
//  5. Back-to-back: start held high continuously -> done every 10 cycles, each result correct.
//  6. OVF_EN: a=8'h7F b=8'h01 ci=0 -> sum=8'h80 co=0 ovf=1; a=8'hFF b=8'h01 -> ovf=0.
//  Plus random a/b/ci vs a+b+ci golden model, WIDTH in {1,8,16}.

Source files
------------

// File: rtl/serial_add_seq.sv
// Bit-serial WIDTH-bit adder: operands are loaded in parallel, then summed LSB-first through one full-adder cell.
// Optional macro SERIAL_ADD_OVF_EN adds a registered two's-complement overflow output (ovf).
module serial_add_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic bit_s_c;
    logic bit_c_c;

    // The single full-adder cell, fed by the operand LSBs and the loop carry.
    always_comb begin
        bit_s_c = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        bit_c_c = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    end

    // Next-state and datapath sequencing.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        co_d    = co_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = ci;
                    cnt_d   = '0;
                    sum_d   = '0;
                    busy_d  = 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end

            S_RUN: begin
                // Shift-based insert keeps WIDTH=1 legal (no reversed part-select).
                sum_d   = (sum_q >> 1) | (WIDTH'(bit_s_c) << (WIDTH - 1));
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = bit_c_c;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    co_d    = bit_c_c;
                    done_d  = 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = carry_q ^ bit_c_c;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign co   = co_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed self-checking bench for serial_add_seq (WIDTH=8 and WIDTH=1 instances).
module tb_serial_add_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       co;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       ci1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       co1;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
    logic       ovf1;
`endif

    int vectors;
    int errors;

    serial_add_seq #(.WIDTH(8)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .ci   (ci),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .co   (co)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    serial_add_seq #(.WIDTH(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .start(start1),
        .a    (a1),
        .b    (b1),
        .ci   (ci1),
        .busy (busy1),
        .done (done1),
        .sum  (sum1),
        .co   (co1)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf  (ovf1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive start with operands during cycle 0; returns at the negedge of cycle 1.
    task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic civ);
        start = 1'b1;
        a     = av;
        b     = bv;
        ci    = civ;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Step negedges from cycle 'from' until done is seen; cyc = -1 on timeout.
    task automatic wait_done(input int from, input int limit, output int cyc);
        cyc = from;
        while (done !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        start1 = 1'b0;
        a = '0; b = '0; ci = 1'b0;
        a1 = '0; b1 = '0; ci1 = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++;
        if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h want 00", sum); end
        vectors++;
        if (co !== 1'b0) begin errors++; $display("FAIL reset_co: got %b want 0", co); end
`ifdef SERIAL_ADD_OVF_EN
        vectors++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_carry_wrap();
        int cyc;
        launch(8'hFF, 8'h01, 1'b0);
        wait_done(1, 30, cyc);
        vectors++;
        if (cyc !== 9) begin errors++; $display("FAIL wrap_latency: got %0d want 9", cyc); end
        vectors++;
        if (sum !== 8'h00) begin errors++; $display("FAIL wrap_sum: got %h want 00", sum); end
        vectors++;
        if (co !== 1'b1) begin errors++; $display("FAIL wrap_co: got %b want 1", co); end
        repeat (3) @(negedge clk);
        vectors++;
        if (sum !== 8'h00 || co !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_hold: got sum=%h co=%b busy=%b want 00/1/0", sum, co, busy);
        end
    endtask

    task automatic test_busy_window();
        launch(8'h3C, 8'h05, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            vectors++;
            if (busy !== (c <= 9) || done !== (c == 9)) begin
                errors++;
                $display("FAIL busy_window_c%0d: got busy=%b done=%b want %b/%b",
                         c, busy, done, (c <= 9), (c == 9));
            end
            if (c == 9) begin
                vectors++;
                if (sum !== 8'h42 || co !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_window_result: got %h/%b want 42/0", sum, co);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        launch(8'h10, 8'h20, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, 30, cyc);
        vectors++;
        if (cyc !== 9) begin errors++; $display("FAIL ignored_latency: got %0d want 9", cyc); end
        vectors++;
        if (sum !== 8'h30 || co !== 1'b0) begin
            errors++;
            $display("FAIL ignored_result: got %h/%b want 30/0", sum, co);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignored_no_queue: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        launch(8'hAA, 8'h55, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || co !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: got busy=%b done=%b sum=%h co=%b want 0/0/00/0",
                     busy, done, sum, co);
        end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        vectors++;
        if (seen !== 0) begin errors++; $display("FAIL midrun_quiet: active cycles=%0d want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] av [3];
        logic [7:0] bv [3];
        logic       cv [3];
        logic [7:0] es [3];
        logic       ec [3];
        int cyc;
        int last;
        av = '{8'h12, 8'hF0, 8'hC8};
        bv = '{8'h34, 8'h0F, 8'h64};
        cv = '{1'b0, 1'b1, 1'b0};
        es = '{8'h46, 8'h00, 8'h2C};
        ec = '{1'b0, 1'b1, 1'b1};
        start = 1'b1;
        a = av[0]; b = bv[0]; ci = cv[0];
        @(negedge clk);
        last = 0;
        for (int i = 0; i < 3; i++) begin
            wait_done(last + 1, last + 30, cyc);
            vectors++;
            if (cyc !== last + 10 - ((i == 0) ? 1 : 0)) begin
                errors++;
                $display("FAIL b2b_period_%0d: done at cycle %0d want %0d",
                         i, cyc, last + 10 - ((i == 0) ? 1 : 0));
            end
            vectors++;
            if (sum !== es[i] || co !== ec[i]) begin
                errors++;
                $display("FAIL b2b_result_%0d: got %h/%b want %h/%b", i, sum, co, es[i], ec[i]);
            end
            if (i < 2) begin
                a = av[i+1]; b = bv[i+1]; ci = cv[i+1];
            end
            if (cyc < 0) break;
            last = cyc;
            @(negedge clk);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
    endtask

`ifdef SERIAL_ADD_OVF_EN
    task automatic test_ovf();
        int cyc;
        launch(8'h7F, 8'h01, 1'b0);
        wait_done(1, 30, cyc);
        vectors++;
        if (sum !== 8'h80 || co !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pos: got %h/%b/%b want 80/0/1", sum, co, ovf);
        end
        repeat (2) @(negedge clk);
        launch(8'hFF, 8'h01, 1'b0);
        wait_done(1, 30, cyc);
        vectors++;
        if (sum !== 8'h00 || co !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_neg: got %h/%b/%b want 00/1/0", sum, co, ovf);
        end
        repeat (2) @(negedge clk);
    endtask
`endif

    task automatic test_width1();
        logic [2:0] vec [3];
        logic [1:0] exp_r;
        int cyc;
        vec = '{3'b111, 3'b100, 3'b011};
        for (int i = 0; i < 3; i++) begin
            exp_r = 2'(vec[i][2]) + 2'(vec[i][1]) + 2'(vec[i][0]);
            start1 = 1'b1;
            a1 = vec[i][2];
            b1 = vec[i][1];
            ci1 = vec[i][0];
            @(negedge clk);
            start1 = 1'b0;
            cyc = 1;
            while (done1 !== 1'b1 && cyc < 10) begin
                @(negedge clk);
                cyc++;
            end
            vectors++;
            if (cyc !== 2) begin errors++; $display("FAIL w1_latency_%0d: got %0d want 2", i, cyc); end
            vectors++;
            if ({co1, sum1} !== exp_r) begin
                errors++;
                $display("FAIL w1_result_%0d: got %b%b want %b", i, co1, sum1, exp_r);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] golden;
        int cyc;
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            golden = 9'(ra) + 9'(rb) + 9'(rc);
            launch(ra, rb, rc);
            wait_done(1, 30, cyc);
            vectors++;
            if (cyc !== 9 || {co, sum} !== golden) begin
                errors++;
                $display("FAIL rand_%0d: %h+%h+%b got %h at cycle %0d want %h at 9",
                         i, ra, rb, rc, {co, sum}, cyc, golden);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        start1  = 1'b0;
        @(negedge clk);
        test_reset();
        test_carry_wrap();
        test_busy_window();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SERIAL_ADD_OVF_EN
        test_ovf();
`endif
        test_width1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
